dll_dlcmsm_ctrl: RTL and testbench

Data Link Control and Management State Machine (DLCMSM) controller for the data link layer. It drives `dlc_state_o` into the DLL datapath in place of a hard-tied Active state. It sequences DL_Inactive → DL_Init (FC_INIT1 → FC_INIT2) → DL_Active and schedules InitFC1/InitFC2 DLLP transmission requests toward the DLLP generator and TX arbiter. It tracks received InitFC and UpdateFC DLLPs and received TLPs to set the FI1 and FI2 flags.

---
 rtl/dll_dlcmsm_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dll_dlcmsm_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dll_dlcmsm_ctrl.sv
// Data Link Control and Management State Machine: sequences Inactive -> FC_INIT1 -> FC_INIT2 -> Active,
// schedules InitFC1/InitFC2 DLLP requests and tracks FI1/FI2 from received DLLPs and TLPs.
module dll_dlcmsm_ctrl #(
    parameter int unsigned RESEND_CYCLES = 1024,
    parameter int unsigned CNT_W         = $clog2(RESEND_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       link_up_i,
    input  logic       rx_dllp_valid_i,
    input  logic [1:0] rx_dllp_kind_i,
    input  logic [1:0] rx_fc_type_i,
    input  logic       rx_tlp_valid_i,
    output logic       initfc_req_o,
    output logic       initfc_phase_o,
    output logic [1:0] initfc_type_o,
    input  logic       initfc_ack_i,
    output logic [1:0] dlc_state_o,
    output logic       dl_up_o,
    output logic       fi1_o,
    output logic       fi2_o
);

    typedef enum logic [1:0] {
        ST_INACTIVE = 2'b00,
        ST_FC_INIT1 = 2'b01,
        ST_FC_INIT2 = 2'b10,
        ST_ACTIVE   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        FC_P   = 2'b00,
        FC_NP  = 2'b01,
        FC_CPL = 2'b10
    } fc_t;

    typedef enum logic [1:0] {
        K_INITFC1  = 2'b00,
        K_INITFC2  = 2'b01,
        K_UPDATEFC = 2'b10,
        K_OTHER    = 2'b11
    } kind_t;

    localparam logic [CNT_W-1:0] L_RELOAD = CNT_W'(RESEND_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    fc_t              r_type, w_type_nxt;
    logic             r_req, w_req_nxt;
    logic             r_phase, w_phase_nxt;
    logic [2:0]       r_mask, w_mask_nxt;
    logic             r_fi1, w_fi1_nxt;
    logic             r_fi2, w_fi2_nxt;
    logic             r_dl_up, w_dl_up_nxt;
    logic             r_set_done, w_set_done_nxt;
    logic [CNT_W-1:0] r_timer, w_timer_nxt;

    logic             w_ack;
    logic             w_valid_type;
    logic             w_fi1_hit;
    logic             w_fi2_hit;
    logic [2:0]       w_type_bit;

    assign w_ack        = initfc_ack_i && r_req;
    assign w_valid_type = (rx_fc_type_i != 2'b11);
    assign w_type_bit   = 3'b001 << rx_fc_type_i;
    assign w_fi1_hit    = rx_dllp_valid_i && w_valid_type &&
                          ((rx_dllp_kind_i == K_INITFC1) || (rx_dllp_kind_i == K_INITFC2));
    assign w_fi2_hit    = rx_tlp_valid_i ||
                          (rx_dllp_valid_i && (rx_dllp_kind_i == K_UPDATEFC)) ||
                          (rx_dllp_valid_i && (rx_dllp_kind_i == K_INITFC2) && w_valid_type);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_INACTIVE;
            r_type     <= FC_P;
            r_req      <= 1'b0;
            r_phase    <= 1'b0;
            r_mask     <= '0;
            r_fi1      <= 1'b0;
            r_fi2      <= 1'b0;
            r_dl_up    <= 1'b0;
            r_set_done <= 1'b0;
            r_timer    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_type     <= w_type_nxt;
            r_req      <= w_req_nxt;
            r_phase    <= w_phase_nxt;
            r_mask     <= w_mask_nxt;
            r_fi1      <= w_fi1_nxt;
            r_fi2      <= w_fi2_nxt;
            r_dl_up    <= w_dl_up_nxt;
            r_set_done <= w_set_done_nxt;
            r_timer    <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_type_nxt     = r_type;
        w_req_nxt      = r_req;
        w_phase_nxt    = r_phase;
        w_mask_nxt     = r_mask;
        w_fi2_nxt      = r_fi2;
        w_set_done_nxt = r_set_done;
        w_timer_nxt    = r_timer;

        if (!link_up_i) begin
            w_state_nxt    = ST_INACTIVE;
            w_type_nxt     = FC_P;
            w_req_nxt      = 1'b0;
            w_phase_nxt    = 1'b0;
            w_mask_nxt     = '0;
            w_fi2_nxt      = 1'b0;
            w_set_done_nxt = 1'b0;
            w_timer_nxt    = '0;
        end else begin
            case (r_state)
                ST_INACTIVE: begin
                    w_state_nxt    = ST_FC_INIT1;
                    w_req_nxt      = 1'b1;
                    w_phase_nxt    = 1'b0;
                    w_type_nxt     = FC_P;
                    w_mask_nxt     = '0;
                    w_fi2_nxt      = 1'b0;
                    w_set_done_nxt = 1'b0;
                    w_timer_nxt    = '0;
                end
                ST_FC_INIT1, ST_FC_INIT2: begin
                    if ((r_state == ST_FC_INIT1) && r_fi1 && r_set_done) begin
                        w_state_nxt    = ST_FC_INIT2;
                        w_phase_nxt    = 1'b1;
                        w_type_nxt     = FC_P;
                        w_req_nxt      = 1'b1;
                        w_set_done_nxt = 1'b0;
                        w_timer_nxt    = '0;
                    end else if ((r_state == ST_FC_INIT2) && r_fi2 && r_set_done) begin
                        w_state_nxt    = ST_ACTIVE;
                        w_req_nxt      = 1'b0;
                        w_set_done_nxt = 1'b0;
                        w_timer_nxt    = '0;
                    end else if (w_ack) begin
                        case (r_type)
                            FC_P:    w_type_nxt = FC_NP;
                            FC_NP:   w_type_nxt = FC_CPL;
                            default: begin
                                w_req_nxt      = 1'b0;
                                w_set_done_nxt = 1'b1;
                                w_timer_nxt    = L_RELOAD;
                            end
                        endcase
                    end else if (!r_req && r_set_done) begin
                        // set_done drops when a resend starts, so a phase change never cuts a set short
                        if (r_timer == '0) begin
                            w_req_nxt      = 1'b1;
                            w_type_nxt     = FC_P;
                            w_set_done_nxt = 1'b0;
                        end else begin
                            w_timer_nxt = r_timer - CNT_W'(1);
                        end
                    end

                    if ((r_state == ST_FC_INIT1) && w_fi1_hit) begin
                        w_mask_nxt = r_mask | w_type_bit;
                    end
                    if ((r_state == ST_FC_INIT2) && w_fi2_hit) begin
                        w_fi2_nxt = 1'b1;
                    end
                end
                default: begin
                    w_req_nxt = 1'b0;
                end
            endcase
        end

        w_fi1_nxt   = &w_mask_nxt;
        w_dl_up_nxt = (w_state_nxt == ST_ACTIVE);
    end

    assign initfc_req_o   = r_req;
    assign initfc_phase_o = r_phase;
    assign initfc_type_o  = r_type;
    assign dlc_state_o    = r_state;
    assign dl_up_o        = r_dl_up;
    assign fi1_o          = r_fi1;
    assign fi2_o          = r_fi2;

endmodule

// File: tb/tb_dll_dlcmsm_ctrl.sv
// Scoreboard bench for dll_dlcmsm_ctrl: expected InitFC requests are queued ahead of stimulus and
// popped by a monitor on every request cycle; state/flag checks are made directly after edges.
module tb_dll_dlcmsm_ctrl;

    localparam int unsigned RC = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       link_up_i;
    logic       rx_dllp_valid_i;
    logic [1:0] rx_dllp_kind_i;
    logic [1:0] rx_fc_type_i;
    logic       rx_tlp_valid_i;
    logic       initfc_req_o;
    logic       initfc_phase_o;
    logic [1:0] initfc_type_o;
    logic       initfc_ack_i;
    logic [1:0] dlc_state_o;
    logic       dl_up_o;
    logic       fi1_o;
    logic       fi2_o;

    dll_dlcmsm_ctrl #(.RESEND_CYCLES(RC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .link_up_i       (link_up_i),
        .rx_dllp_valid_i (rx_dllp_valid_i),
        .rx_dllp_kind_i  (rx_dllp_kind_i),
        .rx_fc_type_i    (rx_fc_type_i),
        .rx_tlp_valid_i  (rx_tlp_valid_i),
        .initfc_req_o    (initfc_req_o),
        .initfc_phase_o  (initfc_phase_o),
        .initfc_type_o   (initfc_type_o),
        .initfc_ack_i    (initfc_ack_i),
        .dlc_state_o     (dlc_state_o),
        .dl_up_o         (dl_up_o),
        .fi1_o           (fi1_o),
        .fi2_o           (fi2_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       ph;
        logic [1:0] ty;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    always @(negedge clk) begin
        if (initfc_req_o === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL req_unexpected: got state=%0d phase=%0d type=%0d, required no request (t=%0t)",
                         dlc_state_o, initfc_phase_o, initfc_type_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if ({dlc_state_o, initfc_phase_o, initfc_type_o} !== mon_e) begin
                    n_fail++;
                    $display("FAIL req_seq: got state=%0d phase=%0d type=%0d, required state=%0d phase=%0d type=%0d (t=%0t)",
                             dlc_state_o, initfc_phase_o, initfc_type_o, mon_e.st, mon_e.ph, mon_e.ty, $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic ph, input logic [1:0] ty, input int n);
        exp_t e;
        e.st = st;
        e.ph = ph;
        e.ty = ty;
        repeat (n) exp_q.push_back(e);
    endtask

    task automatic push_set(input logic [1:0] st, input logic ph);
        push(st, ph, 2'd0, 1);
        push(st, ph, 2'd1, 1);
        push(st, ph, 2'd2, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_send(input logic [1:0] kind, input logic [1:0] ty);
        rx_dllp_valid_i = 1'b1;
        rx_dllp_kind_i  = kind;
        rx_fc_type_i    = ty;
    endtask

    task automatic rx_idle();
        rx_dllp_valid_i = 1'b0;
        rx_dllp_kind_i  = 2'd0;
        rx_fc_type_i    = 2'd0;
        rx_tlp_valid_i  = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        link_up_i    = 1'b1;
        initfc_ack_i = 1'b0;
        rx_idle();

        // Reset held with link up
        repeat (3) tick();
        chk("rst_state", 32'(dlc_state_o), 0);
        chk("rst_req",   32'(initfc_req_o), 0);
        chk("rst_phase", 32'(initfc_phase_o), 0);
        chk("rst_type",  32'(initfc_type_o), 0);
        chk("rst_fi1",   32'(fi1_o), 0);
        chk("rst_fi2",   32'(fi2_o), 0);
        chk("rst_dlup",  32'(dl_up_o), 0);

        // Full bring-up, ack tied high
        push_set(2'd1, 1'b0);
        push_set(2'd2, 1'b1);
        rst_n        = 1'b1;
        initfc_ack_i = 1'b1;
        tick();
        chk("up_state", 32'(dlc_state_o), 1);
        chk("up_req",   32'(initfc_req_o), 1);
        chk("up_phase", 32'(initfc_phase_o), 0);
        chk("up_type",  32'(initfc_type_o), 0);
        rx_send(2'd0, 2'd0); tick();
        rx_send(2'd0, 2'd1); tick();
        rx_send(2'd0, 2'd2); tick();
        rx_idle();
        chk("set1_done_req", 32'(initfc_req_o), 0);
        chk("set1_fi1",      32'(fi1_o), 1);
        chk("set1_state",    32'(dlc_state_o), 1);
        tick();
        chk("init2_state", 32'(dlc_state_o), 2);
        chk("init2_req",   32'(initfc_req_o), 1);
        chk("init2_phase", 32'(initfc_phase_o), 1);
        chk("init2_type",  32'(initfc_type_o), 0);
        rx_send(2'd2, 2'd0); tick();
        rx_idle();
        chk("fi2_set",     32'(fi2_o), 1);
        chk("fi2_state",   32'(dlc_state_o), 2);
        tick(); tick();
        chk("set2_done_req", 32'(initfc_req_o), 0);
        chk("set2_state",    32'(dlc_state_o), 2);
        tick();
        chk("active_state", 32'(dlc_state_o), 3);
        chk("active_dlup",  32'(dl_up_o), 1);
        chk("active_req",   32'(initfc_req_o), 0);
        rx_send(2'd0, 2'd0); tick();
        rx_send(2'd1, 2'd1); tick();
        rx_idle(); tick();
        chk("active_hold", 32'(dlc_state_o), 3);
        chk("active_flags", 32'({fi1_o, fi2_o, dl_up_o}), 32'h7);

        // Link down from Active
        link_up_i = 1'b0;
        tick();
        chk("down_state", 32'(dlc_state_o), 0);
        chk("down_flags", 32'({initfc_req_o, fi1_o, fi2_o, dl_up_o}), 0);

        // Resend cadence with no rx traffic: 3 request cycles then RC idle
        link_up_i = 1'b1;
        push_set(2'd1, 1'b0);
        push_set(2'd1, 1'b0);
        for (int k = 0; k < 22; k++) begin
            tick();
            chk("resend_req",   32'((k % 11) < 3), 32'(initfc_req_o) ^ 32'(0));
            chk("resend_state", 32'(dlc_state_o), 1);
        end
        chk("resend_fi1", 32'(fi1_o), 0);
        link_up_i = 1'b0;
        tick();
        chk("resend_down", 32'({dlc_state_o, initfc_req_o}), 0);

        // Backpressure on NP, partial mask (P, Cpl, reserved type, UpdateFC NP)
        link_up_i    = 1'b1;
        initfc_ack_i = 1'b0;
        push(2'd1, 1'b0, 2'd0, 1);
        push(2'd1, 1'b0, 2'd1, 6);
        push(2'd1, 1'b0, 2'd2, 1);
        tick();
        chk("bp_p_type", 32'(initfc_type_o), 0);
        initfc_ack_i = 1'b1;
        rx_send(2'd0, 2'd0);
        tick();
        initfc_ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_np_req",  32'(initfc_req_o), 1);
            chk("bp_np_type", 32'(initfc_type_o), 1);
            case (i)
                0:       rx_send(2'd0, 2'd2);
                1:       rx_send(2'd0, 2'd3);
                2:       rx_send(2'd2, 2'd1);
                default: rx_idle();
            endcase
            tick();
        end
        rx_idle();
        chk("bp_np_hold", 32'(initfc_type_o), 1);
        initfc_ack_i = 1'b1;
        tick();
        chk("bp_cpl_type", 32'(initfc_type_o), 2);
        tick();
        chk("pm_req",   32'(initfc_req_o), 0);
        chk("pm_fi1",   32'(fi1_o), 0);
        chk("pm_state", 32'(dlc_state_o), 1);
        repeat (4) tick();
        chk("pm_hold_state", 32'(dlc_state_o), 1);
        chk("pm_hold_fi1",   32'(fi1_o), 0);
        link_up_i = 1'b0;
        tick();
        chk("pm_down", 32'(dlc_state_o), 0);

        // Link drop in FC_INIT2 with an ack in the same cycle
        link_up_i    = 1'b1;
        initfc_ack_i = 1'b1;
        push_set(2'd1, 1'b0);
        push(2'd2, 1'b1, 2'd0, 1);
        push(2'd2, 1'b1, 2'd1, 1);
        push(2'd1, 1'b0, 2'd0, 1);
        tick();
        rx_send(2'd0, 2'd0); tick();
        rx_send(2'd1, 2'd1); tick();
        rx_send(2'd0, 2'd2); tick();
        rx_idle(); tick();
        chk("ld_init2", 32'(dlc_state_o), 2);
        rx_send(2'd1, 2'd0); tick();
        rx_idle();
        chk("ld_flags_before", 32'({fi1_o, fi2_o}), 32'h3);
        chk("ld_req_before",   32'(initfc_req_o), 1);
        link_up_i = 1'b0;
        tick();
        chk("ld_state", 32'(dlc_state_o), 0);
        chk("ld_req",   32'(initfc_req_o), 0);
        chk("ld_flags", 32'({fi1_o, fi2_o}), 0);
        link_up_i = 1'b1;
        tick();
        chk("relink_state", 32'(dlc_state_o), 1);
        chk("relink_req",   32'(initfc_req_o), 1);
        chk("relink_pt",    32'({initfc_phase_o, initfc_type_o}), 0);
        initfc_ack_i = 1'b0;
        link_up_i    = 1'b0;
        tick();
        chk("final_state", 32'(dlc_state_o), 0);
        repeat (2) tick();
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
